ov7670_config_sequencer: RTL and testbench

- Reader/consumer side of the OV7670 configuration ROM.
- Walks the ROM from address 0 and decodes each 16-bit entry {reg[15:8], value[7:0]}.
- Issues one SCCB register write per entry through a ready/start handshake to the SCCB master.
- Entry 16'hFFF0 inserts a timed delay; entry 16'hFFFF ends the sequence. Sits between the config ROM and the SCCB master; drives the camera bring-up done flag.

---
 rtl/ov7670_pkg.sv | 33 +++
 rtl/ov7670_config_sequencer.sv | 107 ++++++++++
 tb/tb_ov7670_config_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 configuration sequencer: ROM markers, FSM states and
// delay-counter sizing helpers.
package ov7670_pkg;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StSend,
        StWaitAck,
        StDelay,
        StFinish
    } cfg_state_t;

    function automatic int unsigned delay_cycles(input int unsigned clk_freq,
                                                 input int unsigned delay_ms);
        int unsigned c;
        c = clk_freq / 1000 * delay_ms;
        return (c == 0) ? 1 : c;
    endfunction

    // Counter only has to hold DELAY_CYCLES-1.
    function automatic int unsigned delay_width(input int unsigned clk_freq,
                                                input int unsigned delay_ms);
        int unsigned c;
        c = delay_cycles(clk_freq, delay_ms);
        return (c <= 2) ? 1 : $clog2(c);
    endfunction

endpackage

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and issues one SCCB write per entry, honouring delay and end
// markers, then raises a sticky done flag.
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25000000,
    parameter int unsigned DELAY_MS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    input  logic        sccb_ready,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DelayCycles = delay_cycles(CLK_FREQ, DELAY_MS);
    localparam int unsigned CntW        = delay_width(CLK_FREQ, DELAY_MS);
    localparam logic [CntW-1:0] CntLoad = CntW'(DelayCycles - 1);

    cfg_state_t      state;
    logic [CntW-1:0] delay_cnt;
    logic            ack_armed;

    // Gated by ready in the same cycle so a request can never go out while the master is busy.
    assign sccb_start = (state == StSend) && sccb_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            rom_addr  <= 8'd0;
            sccb_reg  <= 8'd0;
            sccb_data <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            delay_cnt <= '0;
            ack_armed <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        rom_addr <= 8'd0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= StFetch;
                    end
                end
                StFetch: state <= StDecode;
                StDecode: begin
                    if (rom_dout == CFG_END) begin
                        state <= StFinish;
                    end else if (rom_dout == CFG_DELAY) begin
                        delay_cnt <= CntLoad;
                        state     <= StDelay;
                    end else begin
                        sccb_reg  <= rom_dout[15:8];
                        sccb_data <= rom_dout[7:0];
                        state     <= StSend;
                    end
                end
                StSend: begin
                    if (sccb_ready) begin
                        ack_armed <= 1'b0;
                        state     <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    // First cycle is skipped: ready is still stale the cycle after the request.
                    if (!ack_armed) begin
                        ack_armed <= 1'b1;
                    end else if (sccb_ready) begin
                        if (rom_addr == 8'hFF) begin
                            state <= StFinish;
                        end else begin
                            rom_addr <= rom_addr + 8'd1;
                            state    <= StFetch;
                        end
                    end
                end
                StDelay: begin
                    if (delay_cnt == '0) begin
                        if (rom_addr == 8'hFF) begin
                            state <= StFinish;
                        end else begin
                            rom_addr <= rom_addr + 8'd1;
                            state    <= StFetch;
                        end
                    end else begin
                        delay_cnt <= delay_cnt - CntW'(1);
                    end
                end
                StFinish: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed bench: ROM model, SCCB master model with configurable busy time, write logger.
module tb_ov7670_config_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout = 16'h0;
    logic        sccb_ready;
    logic        sccb_start;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        busy;
    logic        done;

    logic [15:0] rom [0:255];
    logic [15:0] exp_wr [0:511];
    int          n_exp;
    logic [15:0] wr_log [0:511];
    int          wr_cyc [0:511];
    int          n_wr = 0;
    int          n_viol = 0;
    int          cyc = 0;
    int          busy_n = 1;
    int          bcnt = 0;
    logic        force_low = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    ov7670_config_sequencer #(.CLK_FREQ(10000), .DELAY_MS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .sccb_ready (sccb_ready),
        .sccb_start (sccb_start),
        .sccb_reg   (sccb_reg),
        .sccb_data  (sccb_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign sccb_ready = (bcnt == 0) && !force_low;

    initial forever begin
        @(posedge clk);
        rom_dout <= rom[rom_addr];
        if (sccb_start && sccb_ready) bcnt <= busy_n;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (sccb_start) begin
            if (!sccb_ready) n_viol++;
            if (n_wr < 512) begin
                wr_log[n_wr] = {sccb_reg, sccb_data};
                wr_cyc[n_wr] = cyc;
            end
            n_wr++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        check_eq("rst_addr", 32'(rom_addr), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_start", 32'(sccb_start), 32'h0);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k = 0;
        while (!done && k < max) begin
            tick(1);
            k++;
        end
        check_eq(tag, 32'(done), 32'h1);
    endtask

    task automatic wait_writes(input string tag, input int n, input int max);
        int k = 0;
        while (n_wr < n && k < max) begin
            tick(1);
            k++;
        end
        check_eq(tag, 32'(n_wr >= n), 32'h1);
    endtask

    task automatic load_small();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1204;
        rom[3] = 16'hFFFF;
    endtask

    task automatic load_prod();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        for (int i = 2; i < 72; i++) rom[i] = {8'(i), 8'(i * 7)};
        rom[40] = 16'hFF12;
        rom[72] = 16'h13E5;
        rom[73] = 16'hFFFF;
    endtask

    // Expected write list straight from the ROM image: skip delay markers, stop at end marker.
    task automatic build_expected();
        n_exp = 0;
        for (int i = 0; i < 256; i++) begin
            if (rom[i] == 16'hFFFF) break;
            if (rom[i] != 16'hFFF0) begin
                exp_wr[n_exp] = rom[i];
                n_exp++;
            end
        end
    endtask

    task automatic compare_writes(input string tag);
        check_eq({tag, "_count"}, 32'(n_wr), 32'(n_exp));
        for (int i = 0; i < n_exp && i < 512; i++)
            check_eq($sformatf("%s_wr%0d", tag, i), 32'(wr_log[i]), 32'(exp_wr[i]));
    endtask

    initial begin
        int rel;
        int bad;

        // Small image, one-cycle master busy
        load_small();
        build_expected();
        busy_n = 1;
        do_reset();
        n_wr = 0;
        pulse_start();
        wait_done("small_done_to", 500);
        compare_writes("small");
        check_eq("small_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd17);
        check_eq("small_busy", 32'(busy), 32'h0);
        check_eq("small_done", 32'(done), 32'h1);

        // Production-like image, 20-cycle master busy
        load_prod();
        build_expected();
        check_eq("prod_nexp", 32'(n_exp), 32'd72);
        busy_n = 20;
        n_wr = 0;
        pulse_start();
        check_eq("prod_clr_done", 32'(done), 32'h0);
        wait_done("prod_done_to", 5000);
        compare_writes("prod");
        check_eq("prod_last", 32'(wr_log[71]), 32'h13E5);
        check_eq("prod_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd36);

        // Ready held low for 100 cycles at first SEND
        load_small();
        build_expected();
        busy_n = 1;
        force_low = 1'b1;
        n_wr = 0;
        pulse_start();
        tick(100);
        check_eq("hold_no_pulse", 32'(n_wr), 32'h0);
        force_low = 1'b0;
        rel = cyc;
        wait_writes("hold_pulse_to", 1, 10);
        check_eq("hold_first_cyc", 32'(wr_cyc[0]), 32'(rel + 1));
        check_eq("hold_wr0", 32'(wr_log[0]), 32'h1280);
        check_eq("hold_one_pulse", 32'(n_wr), 32'h1);
        wait_done("hold_done_to", 500);

        // Start mid-pass ignored; restart after done
        load_prod();
        build_expected();
        n_wr = 0;
        pulse_start();
        wait_writes("mid_w3_to", 3, 200);
        pulse_start();
        check_eq("mid_busy", 32'(busy), 32'h1);
        wait_done("mid_done_to", 2000);
        compare_writes("mid");
        n_wr = 0;
        pulse_start();
        check_eq("re_done_clr", 32'(done), 32'h0);
        check_eq("re_busy", 32'(busy), 32'h1);
        check_eq("re_addr", 32'(rom_addr), 32'h0);
        wait_writes("re_w1_to", 1, 50);
        check_eq("re_wr0", 32'(wr_log[0]), 32'h1280);
        wait_done("re_done_to", 2000);

        // Reset during DELAY
        load_small();
        build_expected();
        n_wr = 0;
        pulse_start();
        wait_writes("rd_w1_to", 1, 50);
        tick(6);
        do_reset();
        n_wr = 0;
        pulse_start();
        wait_done("rd_done_to", 500);
        compare_writes("rd_clean");

        // Reset during WAIT_ACK
        busy_n = 20;
        n_wr = 0;
        pulse_start();
        wait_writes("rw_w1_to", 1, 50);
        do_reset();
        n_wr = 0;
        pulse_start();
        wait_done("rw_done_to", 500);
        compare_writes("rw_clean");

        // No end marker: must stop at 255 without wrapping
        for (int i = 0; i < 256; i++) rom[i] = 16'h0101;
        busy_n = 1;
        n_wr = 0;
        pulse_start();
        wait_done("nw_done_to", 3000);
        check_eq("nw_count", 32'(n_wr), 32'd256);
        check_eq("nw_addr", 32'(rom_addr), 32'hFF);
        check_eq("nw_busy", 32'(busy), 32'h0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (wr_log[i] != 16'h0101) bad++;
        check_eq("nw_vals", 32'(bad), 32'h0);
        tick(20);
        check_eq("nw_no_more", 32'(n_wr), 32'd256);

        check_eq("no_start_while_busy", 32'(n_viol), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
